// File: rtl/bist_pkg.sv
// Shared types, tap constants and next-state helpers for the BIST stimulus/signature controller.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} bist_state_e;

    localparam int unsigned LFSR_W = 18;
    localparam int unsigned MISR_W = 19;

    // Taps: LFSR x^18+x^11+1, MISR x^19+x^6+x^2+x+1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 18'h20400;
    localparam logic [MISR_W-1:0] MISR_TAPS = 19'h40023;

    function automatic logic [LFSR_W-1:0] next_lfsr(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [MISR_W-1:0] next_misr(input logic [MISR_W-1:0] m,
                                                    input logic [MISR_W-1:0] d);
        return {m[MISR_W-2:0], ^(m & MISR_TAPS)} ^ d;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 19-bit multiple-input signature register; load takes priority over compaction.
module bist_misr
    import bist_pkg::*;
(
    input  logic              CK,
    input  logic              RST,
    input  logic              load,
    input  logic              en,
    input  logic [MISR_W-1:0] seed,
    input  logic [MISR_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;

    always_ff @(posedge CK) begin
        if (RST || load) begin
            sig_q <= seed;
        end else if (en) begin
            sig_q <= next_misr(sig_q, din);
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_stim_sig_ctrl.sv
// LFSR stimulus + MISR compaction controller for the 5-flop controller CUT.
// Optional BIST_PO_REG_EN: registers po_vec once before the MISR (RUN grows by one cycle).
module bist_stim_sig_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned    PI_W      = 18,
    parameter int unsigned    PO_W      = 19,
    parameter int unsigned    CLR_BIT   = 17,
    parameter int unsigned    CLR_CYC   = 2,
    parameter int unsigned    PAT_CNT   = 1024,
    parameter logic [PI_W-1:0] LFSR_SEED = 'h1,
    parameter logic [PO_W-1:0] MISR_SEED = '0
) (
    input  logic                         CK,
    input  logic                         RST,
    input  logic                         start,
    input  logic [PO_W-1:0]              po_vec,
    input  logic [PO_W-1:0]              golden,
    output logic [PI_W-1:0]              pi_vec,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [PO_W-1:0]              signature,
    output logic [$clog2(PAT_CNT+1)-1:0] pat_idx
);

    localparam int unsigned IDX_W = $clog2(PAT_CNT + 1);
    localparam int unsigned CLR_W = $clog2(CLR_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_CNT - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);
    localparam logic [PI_W-1:0]  CLR_MASK = PI_W'(1) << CLR_BIT;
    localparam logic [PI_W-1:0]  SEED_EFF = (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;

    if (PI_W != LFSR_W || PO_W != MISR_W) begin : g_bad_width
        $error("bist_stim_sig_ctrl: tap masks only defined for PI_W=18, PO_W=19");
    end
    if (PAT_CNT < 1 || CLR_CYC < 1 || CLR_BIT >= PI_W) begin : g_bad_param
        $error("bist_stim_sig_ctrl: PAT_CNT and CLR_CYC must be >=1, CLR_BIT < PI_W");
    end

    bist_state_e       state_q;
    logic [PI_W-1:0]   lfsr_q;
    logic [PI_W-1:0]   lfsr_d;
    logic [PI_W-1:0]   pi_q;
    logic              busy_q;
    logic              done_q;
    logic [CLR_W-1:0]  clr_cnt_q;
    logic [IDX_W-1:0]  pat_idx_q;
    logic              misr_load;
    logic              misr_en;
    logic [PO_W-1:0]   misr_din;
    logic [PO_W-1:0]   sig;

    assign lfsr_d    = next_lfsr(lfsr_q);
    assign misr_load = (state_q == IDLE || state_q == DONE) && start;

`ifdef BIST_PO_REG_EN
    logic [PO_W-1:0] po_q;
    logic            first_q;

    always_ff @(posedge CK) begin
        if (RST) begin
            po_q <= '0;
        end else begin
            po_q <= po_vec;
        end
    end

    // The first RUN edge sees a sample taken during CLEAR, so it is skipped.
    assign misr_en  = (state_q == RUN) && !first_q;
    assign misr_din = po_q;
`else
    assign misr_en  = (state_q == RUN);
    assign misr_din = po_vec;
`endif

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_EFF;
            pi_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clr_cnt_q <= '0;
            pat_idx_q <= '0;
`ifdef BIST_PO_REG_EN
            first_q   <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= CLEAR;
                        lfsr_q    <= SEED_EFF;
                        pi_q      <= CLR_MASK;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        clr_cnt_q <= '0;
                        pat_idx_q <= '0;
`ifdef BIST_PO_REG_EN
                        first_q   <= 1'b1;
`endif
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q <= RUN;
                        pi_q    <= lfsr_q & ~CLR_MASK;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    lfsr_q <= lfsr_d;
                    pi_q   <= lfsr_d & ~CLR_MASK;
`ifdef BIST_PO_REG_EN
                    first_q <= 1'b0;
`endif
                    if (misr_en) begin
                        pat_idx_q <= pat_idx_q + 1'b1;
                        if (pat_idx_q == IDX_LAST) begin
                            state_q <= DONE;
                            pi_q    <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    bist_misr u_misr (
        .CK   (CK),
        .RST  (RST),
        .load (misr_load),
        .en   (misr_en),
        .seed (MISR_SEED),
        .din  (misr_din),
        .sig  (sig)
    );

    assign pi_vec    = pi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = done_q && (sig == golden);
    assign signature = sig;
    assign pat_idx   = pat_idx_q;

endmodule

// File: tb/tb_bist_stim_sig_ctrl.sv
// Directed bench: PAT_CNT=8, CLR_CYC=2, LFSR_SEED=1, MISR_SEED=0; po_vec is either 19'h1 or {1'b0, pi_vec}.
module tb_bist_stim_sig_ctrl;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [18:0] po_vec;
    logic [18:0] golden = '0;
    logic [17:0] pi_vec;
    logic        busy;
    logic        done;
    logic        pass;
    logic [18:0] signature;
    logic [3:0]  pat_idx;
    logic        cut_mode = 1'b0;

    int tests = 0;
    int fails = 0;

    localparam logic [18:0] SIG_CONST = 19'h00091;  // 8 updates, po_vec=1
    localparam logic [18:0] SIG_CUT   = 19'h0006C;  // 8 updates, po_vec={0,pi_vec}

    assign po_vec = cut_mode ? {1'b0, pi_vec} : 19'h1;

    always #5 CK = ~CK;

    bist_stim_sig_ctrl #(
        .PI_W      (18),
        .PO_W      (19),
        .CLR_BIT   (17),
        .CLR_CYC   (2),
        .PAT_CNT   (8),
        .LFSR_SEED (18'h1),
        .MISR_SEED (19'h0)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .start     (start),
        .po_vec    (po_vec),
        .golden    (golden),
        .pi_vec    (pi_vec),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .pat_idx   (pat_idx)
    );

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        tests++; if (pi_vec !== 18'h0) begin fails++; $display("FAIL reset_pi got %h want 0", pi_vec); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL reset_pass got %b want 0", pass); end
        tests++; if (signature !== 19'h0) begin fails++; $display("FAIL reset_sig got %h want 0", signature); end
        tests++; if (pat_idx !== 4'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", pat_idx); end
        RST = 1'b0;
        tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL idle_hold busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_run_sequence();
        cut_mode = 1'b0;
        golden   = SIG_CONST;
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            tests++; if (pi_vec !== 18'h20000) begin fails++; $display("FAIL clear_pi[%0d] got %h want 20000", i, pi_vec); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clear_busy[%0d] got %b want 1", i, busy); end
            tests++; if (signature !== 19'h0) begin fails++; $display("FAIL clear_sig[%0d] got %h want 0", i, signature); end
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            logic [17:0] exp_pi;
            exp_pi = 18'h1 << k;
            tests++; if (pi_vec !== exp_pi) begin fails++; $display("FAIL run_pi[%0d] got %h want %h", k, pi_vec, exp_pi); end
            tests++; if (pi_vec[17] !== 1'b0) begin fails++; $display("FAIL run_clr[%0d] got %b want 0", k, pi_vec[17]); end
            tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL run_flags[%0d] busy=%b done=%b want 1/0", k, busy, done); end
            tick();
        end
`ifdef BIST_PO_REG_EN
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL run_extra_done got %b want 0", done); end
        tick();
`endif
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL done_latency got %b want 1", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL done_busy got %b want 0", busy); end
        tests++; if (pi_vec !== 18'h0) begin fails++; $display("FAIL done_pi got %h want 0", pi_vec); end
        tests++; if (signature !== SIG_CONST) begin fails++; $display("FAIL done_sig got %h want %h", signature, SIG_CONST); end
        tests++; if (pat_idx !== 4'd8) begin fails++; $display("FAIL done_idx got %0d want 8", pat_idx); end
        tests++; if (pass !== 1'b1) begin fails++; $display("FAIL done_pass got %b want 1", pass); end
        golden = 19'h00090;
        #1;
        tests++; if (pass !== 1'b0) begin fails++; $display("FAIL bad_golden_pass got %b want 0", pass); end
        golden = SIG_CONST;
        tick();
        tick();
        tests++; if (done !== 1'b1 || signature !== SIG_CONST) begin fails++; $display("FAIL done_hold done=%b sig=%h want 1/%h", done, signature, SIG_CONST); end
    endtask

    task automatic test_back_to_back();
        cut_mode = 1'b1;
        golden   = SIG_CUT;
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL rerun_start[%0d] done=%b busy=%b want 0/1", r, done, busy); end
            tests++; if (signature !== 19'h0) begin fails++; $display("FAIL rerun_seed[%0d] got %h want 0", r, signature); end
            wait_done();
            tests++; if (done !== 1'b1) begin fails++; $display("FAIL rerun_timeout[%0d] done=%b want 1", r, done); end
            tests++; if (signature !== SIG_CUT) begin fails++; $display("FAIL rerun_sig[%0d] got %h want %h", r, signature, SIG_CUT); end
            tests++; if (pass !== 1'b1) begin fails++; $display("FAIL rerun_pass[%0d] got %b want 1", r, pass); end
        end
    endtask

    task automatic test_start_ignored();
        cut_mode = 1'b0;
        golden   = SIG_CONST;
        pulse_start();
        pulse_start();
        tick();
        tick();
        pulse_start();
        tick();
        pulse_start();
        wait_done();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL ign_timeout done=%b want 1", done); end
        tests++; if (pat_idx !== 4'd8) begin fails++; $display("FAIL ign_idx got %0d want 8", pat_idx); end
        tests++; if (signature !== SIG_CONST) begin fails++; $display("FAIL ign_sig got %h want %h", signature, SIG_CONST); end
    endtask

    task automatic test_reset_midrun();
        cut_mode = 1'b1;
        pulse_start();
        for (int i = 0; i < 7; i++) tick();
        tests++; if (busy !== 1'b1 || pat_idx === 4'd0) begin fails++; $display("FAIL mid_running busy=%b idx=%0d want 1/nonzero", busy, pat_idx); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tests++; if (pi_vec !== 18'h0) begin fails++; $display("FAIL mid_rst_pi got %h want 0", pi_vec); end
        tests++; if (signature !== 19'h0) begin fails++; $display("FAIL mid_rst_sig got %h want 0", signature); end
        tests++; if (pat_idx !== 4'd0) begin fails++; $display("FAIL mid_rst_idx got %0d want 0", pat_idx); end
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_rst_flags done=%b busy=%b want 0/0", done, busy); end
        tick();
        tick();
        tests++; if (busy !== 1'b0 || pi_vec !== 18'h0) begin fails++; $display("FAIL mid_rst_idle busy=%b pi=%h want 0/0", busy, pi_vec); end
    endtask

    initial begin
        test_reset();
        test_run_sequence();
        test_back_to_back();
        test_start_ignored();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
